// File: rtl/sram_8r4w_pipe_prev_if.sv
// Bus between the request source, the SRAM front pipeline stage and the SRAM itself.
// Read/write ports are packed per-port arrays: index N is port N.
interface sram_8r4w_pipe_prev_if #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8
);
    logic [7:0][SRAM_INDEX-1:0] addr_i;
    logic [7:0]                 re_i;
    logic [3:0][SRAM_INDEX-1:0] addr_wr_i;
    logic [3:0]                 we_i;
    logic [3:0][SRAM_WIDTH-1:0] data_wr_i;

    logic [7:0][SRAM_DEPTH-1:0] decoded_addr_o;
    logic [3:0][SRAM_DEPTH-1:0] decoded_addr_wr_o;
    logic [3:0]                 we_o;
    logic [3:0][SRAM_WIDTH-1:0] data_wr_o;
    logic [7:0]                 bypass_valid_o;
    logic [7:0][SRAM_WIDTH-1:0] bypass_data_o;
    logic                       init_done_o;

    modport master (
        output addr_i, re_i, addr_wr_i, we_i, data_wr_i,
        input  decoded_addr_o, decoded_addr_wr_o, we_o, data_wr_o,
               bypass_valid_o, bypass_data_o, init_done_o
    );

    modport slave (
        input  addr_i, re_i, addr_wr_i, we_i, data_wr_i,
        output decoded_addr_o, decoded_addr_wr_o, we_o, data_wr_o,
               bypass_valid_o, bypass_data_o, init_done_o
    );
endinterface

// File: rtl/sram_8r4w_pipe_prev.sv
// Front pipeline stage of the 8R/4W decoded-address SRAM: one-hot decode, collision
// bypass, and a post-reset sequencer that writes entry k = k for k < INIT_COUNT.
module sram_8r4w_pipe_prev #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8,
    parameter int INIT_COUNT = 32
) (
    input logic                   clk,
    input logic                   reset,
    sram_8r4w_pipe_prev_if.slave  bus
);
    localparam int NUM_RD = 8;
    localparam int NUM_WR = 4;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef logic [SRAM_DEPTH-1:0] onehot_t;
    typedef logic [SRAM_INDEX:0]   cnt_t;

    // Indices at or above SRAM_DEPTH match no bit and decode to all-zero.
    function automatic onehot_t decode(input cnt_t idx);
        onehot_t res;
        res = '0;
        for (int i = 0; i < SRAM_DEPTH; i++) begin
            res[i] = (int'(idx) == i);
        end
        return res;
    endfunction

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;

    logic [NUM_RD-1:0][SRAM_DEPTH-1:0] dec_rd_q, dec_rd_d;
    logic [NUM_WR-1:0][SRAM_DEPTH-1:0] dec_wr_q, dec_wr_d;
    logic [NUM_WR-1:0]                 we_q, we_d;
    logic [NUM_WR-1:0][SRAM_WIDTH-1:0] data_wr_q, data_wr_d;
    logic [NUM_RD-1:0]                 byp_valid_q, byp_valid_d;
    logic [NUM_RD-1:0][SRAM_WIDTH-1:0] byp_data_q, byp_data_d;
    logic                              init_done_q, init_done_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        dec_rd_d    = '0;
        dec_wr_d    = '0;
        we_d        = '0;
        data_wr_d   = '0;
        byp_valid_d = '0;
        byp_data_d  = '0;

        case (state_q)
            ST_INIT: begin
                we_d[0]        = 1'b1;
                dec_wr_d[0]    = decode(cnt_q);
                data_wr_d[0]   = SRAM_WIDTH'(cnt_q);
                cnt_d          = cnt_q + cnt_t'(1);
                if (int'(cnt_q) == INIT_COUNT - 1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int r = 0; r < NUM_RD; r++) begin
                    dec_rd_d[r] = bus.re_i[r] ? decode({1'b0, bus.addr_i[r]}) : '0;
                end
                for (int w = 0; w < NUM_WR; w++) begin
                    dec_wr_d[w] = decode({1'b0, bus.addr_wr_i[w]});
                end
                we_d      = bus.we_i;
                data_wr_d = bus.data_wr_i;
                // Ascending scan lets the highest matching write port win, as in the SRAM.
                for (int r = 0; r < NUM_RD; r++) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (bus.re_i[r] && bus.we_i[w] &&
                            bus.addr_wr_i[w] == bus.addr_i[r] &&
                            int'(bus.addr_i[r]) < SRAM_DEPTH) begin
                            byp_valid_d[r] = 1'b1;
                            byp_data_d[r]  = bus.data_wr_i[w];
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        init_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            dec_rd_q    <= '0;
            dec_wr_q    <= '0;
            we_q        <= '0;
            data_wr_q   <= '0;
            byp_valid_q <= '0;
            byp_data_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dec_rd_q    <= dec_rd_d;
            dec_wr_q    <= dec_wr_d;
            we_q        <= we_d;
            data_wr_q   <= data_wr_d;
            byp_valid_q <= byp_valid_d;
            byp_data_q  <= byp_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.decoded_addr_o    = dec_rd_q;
    assign bus.decoded_addr_wr_o = dec_wr_q;
    assign bus.we_o              = we_q;
    assign bus.data_wr_o         = data_wr_q;
    assign bus.bypass_valid_o    = byp_valid_q;
    assign bus.bypass_data_o     = byp_data_q;
    assign bus.init_done_o       = init_done_q;
endmodule
